// File: rtl/nebula_flit_ejector.sv
// NoC local-port ejector: reassembles HEAD/BODY/TAIL or SINGLE flits into one wide packet.
// Event counters are built only when NEBULA_EJECT_STATS_EN is defined; otherwise they read as zero.

package nebula_pkg;
    localparam int COORD_WIDTH     = 4;
    localparam int PACKET_ID_WIDTH = 8;

    typedef enum logic [1:0] {
        FLIT_HEAD   = 2'd0,
        FLIT_BODY   = 2'd1,
        FLIT_TAIL   = 2'd2,
        FLIT_SINGLE = 2'd3
    } flit_type_e;

    typedef struct packed {
        flit_type_e                 flit_type;
        logic [COORD_WIDTH-1:0]     dest_x;
        logic [COORD_WIDTH-1:0]     dest_y;
        logic [COORD_WIDTH-1:0]     src_x;
        logic [COORD_WIDTH-1:0]     src_y;
        logic [PACKET_ID_WIDTH-1:0] packet_id;
        logic [31:0]                payload;
    } noc_flit_t;
endpackage

module nebula_flit_ejector
    import nebula_pkg::*;
#(
    parameter int unsigned NODE_X    = 0,
    parameter int unsigned NODE_Y    = 0,
    parameter int unsigned MAX_FLITS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flit_in_valid,
    output logic                       flit_in_ready,
    input  noc_flit_t                  flit_in,
    output logic                       pkt_valid,
    input  logic                       pkt_ready,
    output logic [COORD_WIDTH-1:0]     pkt_src_x,
    output logic [COORD_WIDTH-1:0]     pkt_src_y,
    output logic [PACKET_ID_WIDTH-1:0] pkt_id,
    output logic [4:0]                 pkt_len,
    output logic [MAX_FLITS*32-1:0]    pkt_data,
    output logic [15:0]                misroute_cnt,
    output logic [15:0]                proto_err_cnt,
    output logic [15:0]                pkt_cnt
);

    localparam logic [COORD_WIDTH-1:0] NODE_X_C = COORD_WIDTH'(NODE_X);
    localparam logic [COORD_WIDTH-1:0] NODE_Y_C = COORD_WIDTH'(NODE_Y);
    localparam logic [4:0]             MAX_C    = 5'(MAX_FLITS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSEMBLE = 2'd1,
        DRAIN    = 2'd2,
        DELIVER  = 2'd3
    } state_e;

    state_e                     state_q, state_d;
    logic [4:0]                 count_q, count_d;
    logic [COORD_WIDTH-1:0]     src_x_q, src_x_d;
    logic [COORD_WIDTH-1:0]     src_y_q, src_y_d;
    logic [PACKET_ID_WIDTH-1:0] id_q, id_d;
    logic [4:0]                 len_q, len_d;
    logic [MAX_FLITS*32-1:0]    data_q, data_d;

    logic accept, is_start, dest_match, id_match;
    logic idle_proc, store_en;
    logic misroute_inc, proto_inc, pkt_inc;

    assign flit_in_ready = (state_q != DELIVER);
    assign pkt_valid     = (state_q == DELIVER);
    assign pkt_src_x     = src_x_q;
    assign pkt_src_y     = src_y_q;
    assign pkt_id        = id_q;
    assign pkt_len       = len_q;
    assign pkt_data      = data_q;

    assign accept     = flit_in_valid && flit_in_ready;
    assign is_start   = (flit_in.flit_type == FLIT_HEAD) || (flit_in.flit_type == FLIT_SINGLE);
    assign dest_match = (flit_in.dest_x == NODE_X_C) && (flit_in.dest_y == NODE_Y_C);
    assign id_match   = (flit_in.packet_id == id_q);

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        src_x_d      = src_x_q;
        src_y_d      = src_y_q;
        id_d         = id_q;
        len_d        = len_q;
        data_d       = data_q;
        idle_proc    = 1'b0;
        store_en     = 1'b0;
        misroute_inc = 1'b0;
        proto_inc    = 1'b0;
        pkt_inc      = 1'b0;

        case (state_q)
            IDLE: idle_proc = accept;
            ASSEMBLE: begin
                if (accept) begin
                    if (is_start) begin
                        // A new packet start abandons the partial one and is handled as if idle.
                        proto_inc = 1'b1;
                        idle_proc = 1'b1;
                    end else if (!id_match) begin
                        proto_inc = 1'b1;
                    end else if (flit_in.flit_type == FLIT_TAIL) begin
                        if (count_q >= MAX_C) begin
                            proto_inc = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            store_en = 1'b1;
                            len_d    = count_q + 5'd1;
                            state_d  = DELIVER;
                        end
                    end else if (count_q + 5'd1 >= MAX_C) begin
                        proto_inc = 1'b1;
                        state_d   = DRAIN;
                    end else begin
                        store_en = 1'b1;
                        count_d  = count_q + 5'd1;
                    end
                end
            end
            DRAIN: begin
                if (accept && flit_in.flit_type == FLIT_TAIL) begin
                    state_d = IDLE;
                end
            end
            DELIVER: begin
                if (pkt_ready) begin
                    state_d = IDLE;
                    pkt_inc = 1'b1;
                    data_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (idle_proc) begin
            case (flit_in.flit_type)
                FLIT_SINGLE, FLIT_HEAD: begin
                    if (dest_match) begin
                        data_d        = '0;
                        data_d[31:0]  = flit_in.payload;
                        src_x_d       = flit_in.src_x;
                        src_y_d       = flit_in.src_y;
                        id_d          = flit_in.packet_id;
                        count_d       = 5'd1;
                        if (flit_in.flit_type == FLIT_SINGLE) begin
                            len_d   = 5'd1;
                            state_d = DELIVER;
                        end else begin
                            state_d = ASSEMBLE;
                        end
                    end else begin
                        misroute_inc = 1'b1;
                        state_d      = (flit_in.flit_type == FLIT_HEAD) ? DRAIN : IDLE;
                    end
                end
                default: begin
                    proto_inc = 1'b1;
                    state_d   = IDLE;
                end
            endcase
        end

        if (store_en) begin
            for (int unsigned k = 0; k < MAX_FLITS; k++) begin
                if (count_q == 5'(k)) begin
                    data_d[32*k +: 32] = flit_in.payload;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            src_x_q <= '0;
            src_y_q <= '0;
            id_q    <= '0;
            len_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            src_x_q <= src_x_d;
            src_y_q <= src_y_d;
            id_q    <= id_d;
            len_q   <= len_d;
            data_q  <= data_d;
        end
    end

`ifdef NEBULA_EJECT_STATS_EN
    logic [15:0] misroute_cnt_q, misroute_cnt_d;
    logic [15:0] proto_err_cnt_q, proto_err_cnt_d;
    logic [15:0] pkt_cnt_q, pkt_cnt_d;

    always_comb begin
        misroute_cnt_d  = misroute_cnt_q;
        proto_err_cnt_d = proto_err_cnt_q;
        pkt_cnt_d       = pkt_cnt_q;
        if (misroute_inc && misroute_cnt_q != '1) misroute_cnt_d = misroute_cnt_q + 16'd1;
        if (proto_inc && proto_err_cnt_q != '1)   proto_err_cnt_d = proto_err_cnt_q + 16'd1;
        if (pkt_inc && pkt_cnt_q != '1)           pkt_cnt_d = pkt_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            misroute_cnt_q  <= '0;
            proto_err_cnt_q <= '0;
            pkt_cnt_q       <= '0;
        end else begin
            misroute_cnt_q  <= misroute_cnt_d;
            proto_err_cnt_q <= proto_err_cnt_d;
            pkt_cnt_q       <= pkt_cnt_d;
        end
    end

    assign misroute_cnt  = misroute_cnt_q;
    assign proto_err_cnt = proto_err_cnt_q;
    assign pkt_cnt       = pkt_cnt_q;
`else
    logic unused_stats;
    assign unused_stats  = misroute_inc | proto_inc | pkt_inc;
    assign misroute_cnt  = '0;
    assign proto_err_cnt = '0;
    assign pkt_cnt       = '0;
`endif

endmodule

// File: tb/tb_nebula_flit_ejector.sv
// Scoreboard bench for nebula_flit_ejector: directed scenarios plus randomized packet traffic
// checked against a packet-level reference model.

module tb_nebula_flit_ejector;
    import nebula_pkg::*;

    localparam int unsigned NX = 1;
    localparam int unsigned NY = 0;
    localparam int unsigned MF = 4;
    localparam int unsigned DW = MF * 32;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       flit_in_valid = 1'b0;
    logic                       flit_in_ready;
    noc_flit_t                  flit_in = '0;
    logic                       pkt_valid;
    logic                       pkt_ready = 1'b1;
    logic [COORD_WIDTH-1:0]     pkt_src_x, pkt_src_y;
    logic [PACKET_ID_WIDTH-1:0] pkt_id;
    logic [4:0]                 pkt_len;
    logic [DW-1:0]              pkt_data;
    logic [15:0]                misroute_cnt, proto_err_cnt, pkt_cnt;

    nebula_flit_ejector #(.NODE_X(NX), .NODE_Y(NY), .MAX_FLITS(MF)) dut (
        .clk(clk), .rst(rst),
        .flit_in_valid(flit_in_valid), .flit_in_ready(flit_in_ready), .flit_in(flit_in),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .pkt_src_x(pkt_src_x), .pkt_src_y(pkt_src_y), .pkt_id(pkt_id), .pkt_len(pkt_len),
        .pkt_data(pkt_data),
        .misroute_cnt(misroute_cnt), .proto_err_cnt(proto_err_cnt), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: packet-level view of the ejector.
    typedef struct {
        logic [COORD_WIDTH-1:0]     sx, sy;
        logic [PACKET_ID_WIDTH-1:0] id;
        logic [4:0]                 len;
        logic [DW-1:0]              data;
    } exp_pkt_t;

    exp_pkt_t                   sb[$];
    bit                         m_open, m_drop;
    logic [PACKET_ID_WIDTH-1:0] m_id;
    logic [COORD_WIDTH-1:0]     m_sx, m_sy;
    logic [31:0]                m_pl[$];
    int unsigned                m_mis, m_err, m_pkts;

    function automatic logic [15:0] ecnt(input int unsigned v);
`ifdef NEBULA_EJECT_STATS_EN
        return (v > 65535) ? 16'hFFFF : 16'(v);
`else
        return (v > 0) ? 16'd0 : 16'd0;
`endif
    endfunction

    task automatic m_deliver();
        exp_pkt_t p;
        p.sx = m_sx; p.sy = m_sy; p.id = m_id;
        p.len = 5'(m_pl.size());
        p.data = '0;
        foreach (m_pl[i]) p.data[32*i +: 32] = m_pl[i];
        sb.push_back(p);
        m_pkts++;
    endtask

    task automatic model_reset();
        m_open = 0; m_drop = 0; m_pl.delete(); sb.delete();
        m_mis = 0; m_err = 0; m_pkts = 0;
    endtask

    task automatic model_flit(input noc_flit_t f, output bit done);
        bit start;
        done  = 0;
        start = (f.flit_type == FLIT_HEAD) || (f.flit_type == FLIT_SINGLE);
        if (m_open && start) begin
            m_err++;
            m_open = 0;
        end
        if (m_open) begin
            if (f.packet_id != m_id) begin
                m_err++;
            end else if (f.flit_type == FLIT_TAIL) begin
                m_pl.push_back(f.payload);
                m_deliver();
                m_open = 0;
                done = 1;
            end else if (m_pl.size() + 1 >= MF) begin
                m_err++;
                m_open = 0;
                m_drop = 1;
            end else begin
                m_pl.push_back(f.payload);
            end
            return;
        end
        if (m_drop) begin
            if (f.flit_type == FLIT_TAIL) m_drop = 0;
            return;
        end
        if (!start) begin
            m_err++;
        end else if (f.dest_x != COORD_WIDTH'(NX) || f.dest_y != COORD_WIDTH'(NY)) begin
            m_mis++;
            if (f.flit_type == FLIT_HEAD) m_drop = 1;
        end else begin
            m_pl.delete();
            m_pl.push_back(f.payload);
            m_id = f.packet_id; m_sx = f.src_x; m_sy = f.src_y;
            if (f.flit_type == FLIT_SINGLE) begin
                m_deliver();
                done = 1;
            end else begin
                m_open = 1;
            end
        end
    endtask

    // pkt_ready driver: forced level or random backpressure.
    bit rand_ready  = 0;
    bit ready_force = 1;
    initial forever begin
        @(posedge clk);
        #1 pkt_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    // Monitor: compares delivered packets and checks hold behaviour under backpressure.
    bit             held = 0;
    logic [255:0]   snap;
    always @(negedge clk) begin
        exp_pkt_t e;
        logic [255:0] cur;
        cur = {pkt_valid, pkt_src_x, pkt_src_y, pkt_id, pkt_len, pkt_data};
        if (rst) begin
            held = 0;
        end else begin
            if (held) chk("hold_stable", cur, snap);
            if (pkt_valid) chk("in_ready_low_in_deliver", flit_in_ready, 0);
            if (pkt_valid && pkt_ready) begin
                held = 0;
                if (sb.size() == 0) begin
                    chk("unexpected_pkt", pkt_valid, 0);
                end else begin
                    e = sb.pop_front();
                    chk("pkt_src_x", pkt_src_x, e.sx);
                    chk("pkt_src_y", pkt_src_y, e.sy);
                    chk("pkt_id", pkt_id, e.id);
                    chk("pkt_len", pkt_len, e.len);
                    chk("pkt_data", pkt_data, e.data);
                end
            end else if (pkt_valid) begin
                held = 1;
                snap = cur;
            end else begin
                held = 0;
            end
        end
    end

    function automatic noc_flit_t mk(input flit_type_e t, input int unsigned dx, input int unsigned dy,
                                     input int unsigned id, input logic [31:0] pl);
        noc_flit_t f;
        f.flit_type = t;
        f.dest_x = COORD_WIDTH'(dx); f.dest_y = COORD_WIDTH'(dy);
        f.src_x = 4'd3; f.src_y = 4'd2;
        f.packet_id = PACKET_ID_WIDTH'(id);
        f.payload = pl;
        return f;
    endfunction

    task automatic send(input noc_flit_t f);
        int unsigned w;
        bit done;
        @(negedge clk);
        flit_in = f;
        flit_in_valid = 1;
        w = 0;
        while (!flit_in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!flit_in_ready) begin
            chk("ready_timeout", flit_in_ready, 1);
            flit_in_valid = 0;
            return;
        end
        @(posedge clk);
        model_flit(f, done);
        #1 flit_in_valid = 0;
        if (done) begin
            @(negedge clk);
            chk("latency_pkt_valid", pkt_valid, 1);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1;
        flit_in_valid = 0;
        @(posedge clk);
        #1 model_reset();
        rst = 0;
    endtask

    task automatic wait_drain();
        int unsigned w = 0;
        ready_force = 1;
        @(negedge clk);
        while ((sb.size() != 0 || pkt_valid) && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk("drain_pending", sb.size(), 0);
        chk("drain_idle", pkt_valid, 0);
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_misroute_cnt"}, misroute_cnt, ecnt(m_mis));
        chk({tag, "_proto_err_cnt"}, proto_err_cnt, ecnt(m_err));
        chk({tag, "_pkt_cnt"}, pkt_cnt, ecnt(m_pkts));
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        do_reset();

        // reset state
        @(negedge clk);
        chk("rst_pkt_valid", pkt_valid, 0);
        chk("rst_in_ready", flit_in_ready, 1);
        chk("rst_header", {pkt_src_x, pkt_src_y, pkt_id, pkt_len}, 0);
        chk("rst_pkt_data", pkt_data, 0);
        chk_counters("rst");

        // single flit delivery
        send(mk(FLIT_SINGLE, 1, 0, 5, 32'hDEAD0005));
        wait_drain();
        chk_counters("single");
        chk("single_pkt_cnt_abs", pkt_cnt, ecnt(1));

        // three-flit packet held under backpressure
        do_reset();
        ready_force = 0;
        send(mk(FLIT_HEAD, 1, 0, 3, 32'hA0));
        send(mk(FLIT_BODY, 1, 0, 3, 32'hA1));
        send(mk(FLIT_TAIL, 1, 0, 3, 32'hA2));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_pkt_valid", pkt_valid, 1);
            chk("bp_in_ready", flit_in_ready, 0);
        end
        chk("bp_len", pkt_len, 3);
        wait_drain();
        chk("bp_back_idle", flit_in_ready, 1);

        // misrouted single
        do_reset();
        send(mk(FLIT_SINGLE, 0, 1, 9, 32'h1234));
        @(negedge clk);
        chk("mis_no_valid", pkt_valid, 0);
        chk("mis_in_ready", flit_in_ready, 1);
        chk("mis_cnt_abs", misroute_cnt, ecnt(1));
        chk_counters("mis");

        // overlong packet aborted, then a normal single
        do_reset();
        send(mk(FLIT_HEAD, 1, 0, 2, 32'hB0));
        for (int i = 1; i <= 4; i++) send(mk(FLIT_BODY, 1, 0, 2, 32'hB0 + 32'(i)));
        send(mk(FLIT_TAIL, 1, 0, 2, 32'hBF));
        @(negedge clk);
        chk("ovf_no_valid", pkt_valid, 0);
        chk("ovf_in_ready", flit_in_ready, 1);
        chk("ovf_err_abs", proto_err_cnt, ecnt(1));
        send(mk(FLIT_SINGLE, 1, 0, 6, 32'hC0C0));
        wait_drain();
        chk_counters("ovf");

        // restarted head discards the partial packet
        do_reset();
        send(mk(FLIT_HEAD, 1, 0, 7, 32'h70));
        send(mk(FLIT_HEAD, 1, 0, 8, 32'h80));
        send(mk(FLIT_BODY, 1, 0, 8, 32'h81));
        send(mk(FLIT_TAIL, 1, 0, 8, 32'h82));
        wait_drain();
        chk("restart_err_abs", proto_err_cnt, ecnt(1));
        chk_counters("restart");

        // reset mid-packet
        do_reset();
        send(mk(FLIT_HEAD, 1, 0, 4, 32'h40));
        send(mk(FLIT_BODY, 1, 0, 4, 32'h41));
        do_reset();
        send(mk(FLIT_TAIL, 1, 0, 4, 32'h42));
        wait_drain();
        chk("midrst_err_abs", proto_err_cnt, ecnt(1));
        chk("midrst_pkt_abs", pkt_cnt, ecnt(0));

        // randomized traffic with backpressure
        do_reset();
        rand_ready = 1;
        for (int p = 0; p < 80; p++) begin
            int unsigned len, id, dx, dy;
            len = $urandom_range(1, 5);
            id  = $urandom_range(0, 15);
            dx  = NX; dy = NY;
            if ($urandom_range(0, 7) == 0) begin dx = 2; dy = 3; end
            if ($urandom_range(0, 9) == 0)
                send(mk(($urandom_range(0, 1) != 0) ? FLIT_BODY : FLIT_TAIL, dx, dy, id, $urandom));
            if (len == 1) begin
                send(mk(FLIT_SINGLE, dx, dy, id, $urandom));
            end else begin
                send(mk(FLIT_HEAD, dx, dy, id, $urandom));
                for (int b = 0; b < int'(len) - 2; b++)
                    send(mk(FLIT_BODY, dx, dy, ($urandom_range(0, 9) == 0) ? id + 1 : id, $urandom));
                if ($urandom_range(0, 9) != 0)
                    send(mk(FLIT_TAIL, dx, dy, id, $urandom));
            end
        end
        send(mk(FLIT_TAIL, NX, NY, 0, 32'h0));
        rand_ready = 0;
        wait_drain();
        chk_counters("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
